mem_port_arbiter: RTL and testbench

Arbitrates one single-ported, synchronous-read unified memory between the pipelined CPU's fetch stage (read-only) and memory stage (read/write). Grants at most one request per cycle, routes each read response back to its requester one cycle later, and drives the fetch-stall signal the hazard logic uses to freeze the PC and the fetch/decode register. Data accesses have priority, since they belong to older instructions; a starvation counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, synchronous-read memory between the CPU fetch
// stage (read-only) and the memory stage (read/write). The data side wins
// by default because it belongs to the older instruction. A saturating
// starvation counter hands fetch one forced grant after it has been denied
// STARVE_LIMIT cycles in a row. Read data comes back one cycle after the
// grant, and a registered tag routes it to the port that issued the read.

module mem_port_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    output logic                     if_gnt,
    output logic                     if_stall,
    output logic                     if_rvalid,
    output logic [DATA_WIDTH-1:0]    if_rdata,

    input  logic                     dm_req,
    input  logic                     dm_we,
    input  logic [ADDRESS_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0]    dm_wdata,
    output logic                     dm_gnt,
    output logic                     dm_stall,
    output logic                     dm_rvalid,
    output logic [DATA_WIDTH-1:0]    dm_rdata,

    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    // Source of the read that is currently returning data from the memory.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IF   = 2'd1,
        SRC_DM   = 2'd2
    } respSrcT;

    localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);

    respSrcT    r_respSrc;
    logic [3:0] r_starveCnt;

    logic w_forced;
    logic w_ifGnt;
    logic w_dmGnt;

    // Pick at most one winner per cycle. Data wins by default. Once fetch
    // has starved long enough it takes priority, but only when it is actually
    // requesting, so a lone data request is never blocked. Reset suppresses
    // every grant.
    always_comb begin
        w_forced = (r_starveCnt == LP_STARVE_LIMIT);
        w_ifGnt  = ~rst & if_req & (~dm_req | w_forced);
        w_dmGnt  = ~rst & dm_req & ~w_ifGnt;
    end

    // Drive the handshake outputs and steer the winner onto the memory bus.
    // The bus reads as zero whenever no access is granted.
    always_comb begin
        if_gnt    = w_ifGnt;
        dm_gnt    = w_dmGnt;
        if_stall  = ~rst & if_req & ~w_ifGnt;
        dm_stall  = ~rst & dm_req & ~w_dmGnt;
        mem_en    = w_ifGnt | w_dmGnt;
        mem_we    = w_dmGnt & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_ifGnt) begin
            mem_addr = if_addr;
        end else if (w_dmGnt) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end
    end

    // Memory read data goes to both consumers unchanged. Each consumer
    // qualifies it with its own rvalid. rvalid is masked while reset is held,
    // so a read granted just before reset never reports its data.
    always_comb begin
        if_rdata  = mem_rdata;
        dm_rdata  = mem_rdata;
        if_rvalid = ~rst & (r_respSrc == SRC_IF);
        dm_rvalid = ~rst & (r_respSrc == SRC_DM);
    end

    // Tag the access granted this cycle so its data can be routed next
    // cycle. Writes produce no response. Also track how long fetch has been
    // denied, saturating at the limit that triggers a forced fetch grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_respSrc   <= SRC_NONE;
            r_starveCnt <= 4'd0;
        end else begin
            if (w_ifGnt) begin
                r_respSrc <= SRC_IF;
            end else if (w_dmGnt && !dm_we) begin
                r_respSrc <= SRC_DM;
            end else begin
                r_respSrc <= SRC_NONE;
            end

            if (w_ifGnt) begin
                r_starveCnt <= 4'd0;
            end else if (if_req && (r_starveCnt != LP_STARVE_LIMIT)) begin
                r_starveCnt <= r_starveCnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. The bench emulates the memory
// attached to the arbiter. It applies a hand-derived vector table, then a
// reset/starvation sequence, then randomized traffic. An abstract reference
// model tracks the priority rule, the fetch denial count, the pending
// response and a reference copy of memory contents.

module tb_mem_port_arbiter;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_stall;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_gnt;
   logic          dm_stall;
   logic          dm_rvalid;
   logic [DW-1:0] dm_rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(
      .DATA_WIDTH   (DW),
      .ADDRESS_WIDTH(AW),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt),
      .if_stall (if_stall),
      .if_rvalid(if_rvalid),
      .if_rdata (if_rdata),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_gnt   (dm_gnt),
      .dm_stall (dm_stall),
      .dm_rvalid(dm_rvalid),
      .dm_rdata (dm_rdata),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Initial memory image: word 4 (byte 0x10) holds an instruction, every
   // other word holds 0x1000_0000 plus its own byte address.
   function automatic logic [31:0] memInit(int idx);
      return (idx == 4) ? 32'h0000_0513 : (32'h1000_0000 | 32'(idx * 4));
   endfunction

   // Synchronous-read memory attached to the arbiter's memory port. It
   // loads its image on the first clock edge.
   logic [31:0] memArr [256];
   logic [31:0] memRdataQ;
   bit          memLoaded = 1'b0;

   always @(posedge clk) begin
      if (!memLoaded) begin
         for (int i = 0; i < 256; i++) memArr[i] <= memInit(i);
         memLoaded <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) memArr[mem_addr[9:2]] <= mem_wdata;
         else        memRdataQ <= memArr[mem_addr[9:2]];
      end
   end

   assign mem_rdata = memRdataQ;

   typedef struct packed {
      logic        ifGnt;
      logic        dmGnt;
      logic        ifStall;
      logic        dmStall;
      logic        memEn;
      logic        memWe;
      logic [31:0] memAddr;
      logic [31:0] memWdata;
      logic        ifRv;
      logic        dmRv;
      logic [31:0] rdata;
   } expT;

   typedef struct {
      logic        rst;
      logic        ifReq;
      logic [31:0] ifAddr;
      logic        dmReq;
      logic        dmWe;
      logic [31:0] dmAddr;
      logic [31:0] dmWdata;
      expT         e;
   } vecT;

   vecT vecs[$];

   // Reference model state, kept at the level of the arbitration rules.
   int          mDenied;
   int          mResp;
   logic [31:0] mRespData;
   logic [31:0] refMem [256];

   function automatic expT E(logic ig, logic dg, logic is, logic ds, logic en, logic we,
                             logic [31:0] addr, logic [31:0] wd, logic irv, logic drv,
                             logic [31:0] rd);
      expT e;
      e.ifGnt = ig; e.dmGnt = dg; e.ifStall = is; e.dmStall = ds;
      e.memEn = en; e.memWe = we; e.memAddr = addr; e.memWdata = wd;
      e.ifRv = irv; e.dmRv = drv; e.rdata = rd;
      return e;
   endfunction

   task automatic addVec(logic r, logic iq, logic [31:0] ia, logic dq, logic dw,
                         logic [31:0] da, logic [31:0] dwd, expT e);
      vecT v;
      v.rst = r; v.ifReq = iq; v.ifAddr = ia; v.dmReq = dq; v.dmWe = dw;
      v.dmAddr = da; v.dmWdata = dwd; v.e = e;
      vecs.push_back(v);
   endtask

   // Drive one cycle's inputs after the falling edge and let them settle.
   task automatic applyStimulus(logic r, logic iq, logic [31:0] ia, logic dq, logic dw,
                                logic [31:0] da, logic [31:0] dwd);
      @(negedge clk);
      rst = r; if_req = iq; if_addr = ia;
      dm_req = dq; dm_we = dw; dm_addr = da; dm_wdata = dwd;
      #1;
   endtask

   task automatic compareField(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(string tag, expT e);
      compareField({tag, ".ifGnt"},    32'(if_gnt),    32'(e.ifGnt));
      compareField({tag, ".dmGnt"},    32'(dm_gnt),    32'(e.dmGnt));
      compareField({tag, ".ifStall"},  32'(if_stall),  32'(e.ifStall));
      compareField({tag, ".dmStall"},  32'(dm_stall),  32'(e.dmStall));
      compareField({tag, ".memEn"},    32'(mem_en),    32'(e.memEn));
      compareField({tag, ".memWe"},    32'(mem_we),    32'(e.memWe));
      compareField({tag, ".memAddr"},  mem_addr,       e.memAddr);
      if (e.memWe || !e.memEn) compareField({tag, ".memWdata"}, mem_wdata, e.memWdata);
      compareField({tag, ".ifRvalid"}, 32'(if_rvalid), 32'(e.ifRv));
      compareField({tag, ".dmRvalid"}, 32'(dm_rvalid), 32'(e.dmRv));
      if (e.ifRv) compareField({tag, ".ifRdata"}, if_rdata, e.rdata);
      if (e.dmRv) compareField({tag, ".dmRdata"}, dm_rdata, e.rdata);
   endtask

   // Predict this cycle's outputs from the current inputs, then advance the
   // model as the clock edge will.
   task automatic modelEval(output expT e);
      logic winIf;
      logic winDm;
      e = '0;
      if (rst) begin
         mDenied = 0;
         mResp   = 0;
         return;
      end
      e.ifRv  = (mResp == 1);
      e.dmRv  = (mResp == 2);
      e.rdata = mRespData;
      winIf = if_req && (!dm_req || mDenied >= LIMIT);
      winDm = dm_req && !winIf;
      e.ifGnt   = winIf;
      e.dmGnt   = winDm;
      e.ifStall = if_req && !winIf;
      e.dmStall = dm_req && !winDm;
      e.memEn   = winIf || winDm;
      e.memWe   = winDm && dm_we;
      e.memAddr = winIf ? if_addr : (winDm ? dm_addr : 32'h0);
      e.memWdata = winDm ? dm_wdata : 32'h0;
      mResp = 0;
      if (winIf) begin
         mResp     = 1;
         mRespData = refMem[if_addr[9:2]];
         mDenied   = 0;
      end else if (winDm) begin
         if (dm_we) begin
            refMem[dm_addr[9:2]] = dm_wdata;
         end else begin
            mResp     = 2;
            mRespData = refMem[dm_addr[9:2]];
         end
      end
      if (if_req && !winIf && mDenied < LIMIT) mDenied++;
   endtask

   function automatic logic [31:0] randAddr();
      return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
   endfunction

   initial begin
      expT         e;
      expT         z;
      logic        ifReqV;
      logic [31:0] ifAddrV;
      logic        dmReqV;
      logic        dmWeV;
      logic [31:0] dmAddrV;
      logic [31:0] dmWdataV;
      logic        rstV;

      rst = 1'b1; if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      mDenied = 0; mResp = 0; mRespData = '0;
      for (int i = 0; i < 256; i++) refMem[i] = memInit(i);
      z = '0;

      // Hand-derived vectors: reset, lone fetch, contention into a forced
      // fetch grant, write then read-back, alternating back-to-back reads,
      // forced mode with a lone data request, and reset right after a read.
      addVec(1, 0, 32'h0,   0, 0, 32'h0,   32'h0,         z);
      addVec(1, 1, 32'h10,  1, 0, 32'h100, 32'h0,         z);
      addVec(0, 1, 32'h10,  0, 0, 32'h0,   32'h0,         E(1,0,0,0,1,0,32'h10, 0,0,0,0));
      addVec(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,         E(0,0,0,0,0,0,32'h0,  0,1,0,32'h0000_0513));
      addVec(0, 1, 32'h20,  1, 0, 32'h100, 32'h0,         E(0,1,1,0,1,0,32'h100,0,0,0,0));
      for (int k = 0; k < 3; k++)
         addVec(0, 1, 32'h20, 1, 0, 32'h100, 32'h0,       E(0,1,1,0,1,0,32'h100,0,0,1,32'h1000_0100));
      addVec(0, 1, 32'h20,  1, 0, 32'h100, 32'h0,         E(1,0,0,1,1,0,32'h20, 0,0,1,32'h1000_0100));
      addVec(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,         E(0,0,0,0,0,0,32'h0,  0,1,0,32'h1000_0020));
      addVec(0, 0, 32'h0,   1, 1, 32'h200, 32'hDEAD_BEEF, E(0,1,0,0,1,1,32'h200,32'hDEAD_BEEF,0,0,0));
      addVec(0, 0, 32'h0,   1, 0, 32'h200, 32'h0,         E(0,1,0,0,1,0,32'h200,0,0,0,0));
      addVec(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,         E(0,0,0,0,0,0,32'h0,  0,0,1,32'hDEAD_BEEF));
      addVec(0, 1, 32'h0,   0, 0, 32'h0,   32'h0,         E(1,0,0,0,1,0,32'h0,  0,0,0,0));
      addVec(0, 0, 32'h0,   1, 0, 32'h40,  32'h0,         E(0,1,0,0,1,0,32'h40, 0,1,0,32'h1000_0000));
      addVec(0, 1, 32'h4,   0, 0, 32'h0,   32'h0,         E(1,0,0,0,1,0,32'h4,  0,0,1,32'h1000_0040));
      addVec(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,         E(0,0,0,0,0,0,32'h0,  0,1,0,32'h1000_0004));
      addVec(0, 1, 32'h8,   1, 0, 32'h100, 32'h0,         E(0,1,1,0,1,0,32'h100,0,0,0,0));
      for (int k = 0; k < 3; k++)
         addVec(0, 1, 32'h8, 1, 0, 32'h100, 32'h0,        E(0,1,1,0,1,0,32'h100,0,0,1,32'h1000_0100));
      addVec(0, 0, 32'h0,   1, 0, 32'h104, 32'h0,         E(0,1,0,0,1,0,32'h104,0,0,1,32'h1000_0100));
      addVec(0, 1, 32'h8,   1, 0, 32'h100, 32'h0,         E(1,0,0,1,1,0,32'h8,  0,0,1,32'h1000_0104));
      addVec(1, 1, 32'hC,   1, 0, 32'h100, 32'h0,         z);
      addVec(0, 1, 32'hC,   0, 0, 32'h0,   32'h0,         E(1,0,0,0,1,0,32'hC,  0,0,0,0));
      addVec(0, 0, 32'h0,   0, 0, 32'h0,   32'h0,         E(0,0,0,0,0,0,32'h0,  0,1,0,32'h1000_000C));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].ifReq, vecs[i].ifAddr, vecs[i].dmReq,
                       vecs[i].dmWe, vecs[i].dmAddr, vecs[i].dmWdata);
         modelEval(e);
         checkOutput($sformatf("vec%0d", i), vecs[i].e);
      end

      // Build up some fetch starvation, reset, then hold contention: reset
      // must clear the count, so fetch wins exactly every LIMIT+1 cycles.
      for (int k = 0; k < 2; k++) begin
         applyStimulus(0, 1, 32'h30, 1, 0, 32'h100, 32'h0);
         modelEval(e);
         checkOutput("preRst", e);
      end
      applyStimulus(1, 1, 32'h30, 1, 0, 32'h100, 32'h0);
      modelEval(e);
      checkOutput("rstHold", e);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 1, 32'h30, 1, 0, 32'h100, 32'h0);
         modelEval(e);
         checkOutput($sformatf("starve%0d", k), e);
         compareField($sformatf("starveIfGnt%0d", k), 32'(if_gnt), 32'((k % 5) == 4));
      end

      // Randomized traffic. Requesters hold their request until granted and
      // occasionally abandon it. Resets are rare.
      ifReqV = 1'b0; ifAddrV = '0;
      dmReqV = 1'b0; dmWeV = 1'b0; dmAddrV = '0; dmWdataV = '0;
      for (int n = 0; n < 800; n++) begin
         rstV = ($urandom_range(0, 49) == 0);
         if (!ifReqV) begin
            if ($urandom_range(0, 2) != 0) begin
               ifReqV  = 1'b1;
               ifAddrV = randAddr();
            end
         end else if ($urandom_range(0, 15) == 0) begin
            ifReqV = 1'b0;
         end
         if (!dmReqV) begin
            if ($urandom_range(0, 2) != 0) begin
               dmReqV   = 1'b1;
               dmWeV    = ($urandom_range(0, 2) == 0);
               dmAddrV  = randAddr();
               dmWdataV = $urandom();
            end
         end else if ($urandom_range(0, 15) == 0) begin
            dmReqV = 1'b0;
         end
         applyStimulus(rstV, ifReqV, ifAddrV, dmReqV, dmWeV, dmAddrV, dmWdataV);
         modelEval(e);
         checkOutput($sformatf("rnd%0d", n), e);
         if (e.ifGnt) ifReqV = 1'b0;
         if (e.dmGnt) dmReqV = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
